// File: rtl/eth_rx_framer_pkg.sv
// Shared constants and types for the GMII receive path (framer, CRC, future TX FCS).
package eth_rx_framer_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int unsigned ETH_MIN_FRAME = 64;
    localparam int unsigned ETH_MAX_FRAME = 1518;

    localparam int unsigned STATUS_W        = 5;
    localparam int unsigned ST_CRC_ERR      = 0;
    localparam int unsigned ST_RUNT         = 1;
    localparam int unsigned ST_OVERSIZE     = 2;
    localparam int unsigned ST_PHY_ERR      = 3;
    localparam int unsigned ST_PREAMBLE_ERR = 4;

    localparam int unsigned BYTE_CNT_W = 11;
    localparam int unsigned PRE_CNT_W  = 4;
    localparam int unsigned DLY_DEPTH  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } rx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational next-state of the reflected Ethernet CRC-32 for one byte, LSB first.
module eth_crc32_byte
    import eth_rx_framer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] acc;

    always_comb begin
        acc = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (acc[0] ^ data[i]) begin
                acc = (acc >> 1) ^ CRC32_POLY;
            end else begin
                acc = acc >> 1;
            end
        end
        crc_out = acc;
    end

endmodule

// File: rtl/eth_rx_framer.sv
// GMII receive framer: strips preamble/SFD and FCS, checks CRC-32, classifies and counts frames.
module eth_rx_framer
    import eth_rx_framer_pkg::*;
#(
    parameter int unsigned MIN_PREAMBLE = 1,
    parameter int unsigned MIN_FRAME    = ETH_MIN_FRAME,
    parameter int unsigned MAX_FRAME    = ETH_MAX_FRAME,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          gmii_rxd,
    input  logic                gmii_rx_dv,
    input  logic                gmii_rx_er,
    output logic [7:0]          rx_data,
    output logic                rx_dv,
    output logic                rx_er,
    output logic                frame_done,
    output logic [STATUS_W-1:0] frame_status,
    output logic [CNT_W-1:0]    good_cnt,
    output logic [CNT_W-1:0]    bad_cnt
);

    localparam logic [PRE_CNT_W-1:0]  MIN_PRE_C   = PRE_CNT_W'(MIN_PREAMBLE);
    localparam logic [BYTE_CNT_W-1:0] MIN_FRAME_C = BYTE_CNT_W'(MIN_FRAME);
    localparam logic [BYTE_CNT_W-1:0] MAX_FRAME_C = BYTE_CNT_W'(MAX_FRAME);
    localparam logic [BYTE_CNT_W-1:0] DLY_FULL_C  = BYTE_CNT_W'(DLY_DEPTH);
    localparam logic [BYTE_CNT_W-1:0] FWD_LIMIT_C = BYTE_CNT_W'(MAX_FRAME + DLY_DEPTH);

    rx_state_t                state;
    logic [PRE_CNT_W-1:0]     pre_cnt;
    logic [BYTE_CNT_W-1:0]    byte_cnt;
    logic [31:0]              crc;
    logic [31:0]              crc_next;
    logic [DLY_DEPTH-1:0][7:0] dly_data;
    logic [DLY_DEPTH-1:0]     dly_er;
    logic                     phy_err;
    logic                     oversize;
    logic                     pre_err;
    logic                     fwd;
    logic                     done_now;
    logic [STATUS_W-1:0]      status_now;

    eth_crc32_byte u_crc (
        .crc_in  (crc),
        .data    (gmii_rxd),
        .crc_out (crc_next)
    );

    // The oldest byte leaves only once the line is full; bytes at index >= MAX_FRAME are not forwarded.
    assign fwd = (byte_cnt >= DLY_FULL_C) && (byte_cnt < FWD_LIMIT_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pre_cnt  <= '0;
            byte_cnt <= '0;
            crc      <= CRC32_INIT;
            dly_data <= '0;
            dly_er   <= '0;
            phy_err  <= 1'b0;
            oversize <= 1'b0;
            pre_err  <= 1'b0;
            rx_data  <= '0;
            rx_dv    <= 1'b0;
            rx_er    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gmii_rx_dv) begin
                        pre_err <= 1'b0;
                        if (gmii_rxd == ETH_PREAMBLE) begin
                            state   <= S_PREAMBLE;
                            pre_cnt <= PRE_CNT_W'(1);
                        end else begin
                            state <= S_DROP;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state <= S_IDLE;
                    end else if (gmii_rxd == ETH_PREAMBLE) begin
                        if (pre_cnt != '1) begin
                            pre_cnt <= pre_cnt + 1'b1;
                        end
                    end else if ((gmii_rxd == ETH_SFD) && (pre_cnt >= MIN_PRE_C)) begin
                        state    <= S_DATA;
                        crc      <= CRC32_INIT;
                        byte_cnt <= '0;
                        phy_err  <= 1'b0;
                        oversize <= 1'b0;
                    end else begin
                        state   <= S_DROP;
                        pre_err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (!gmii_rx_dv) begin
                        state    <= S_IDLE;
                        dly_data <= '0;
                        dly_er   <= '0;
                        rx_data  <= '0;
                        rx_dv    <= 1'b0;
                        rx_er    <= 1'b0;
                    end else begin
                        crc      <= crc_next;
                        dly_data <= {dly_data[DLY_DEPTH-2:0], gmii_rxd};
                        dly_er   <= {dly_er[DLY_DEPTH-2:0], gmii_rx_er};
                        if (byte_cnt != '1) begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                        if (gmii_rx_er) begin
                            phy_err <= 1'b1;
                        end
                        if (byte_cnt >= MAX_FRAME_C) begin
                            oversize <= 1'b1;
                        end
                        rx_dv   <= fwd;
                        rx_er   <= fwd & dly_er[DLY_DEPTH-1];
                        rx_data <= fwd ? dly_data[DLY_DEPTH-1] : '0;
                    end
                end
                S_DROP: begin
                    if (!gmii_rx_dv) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Classification happens on the cycle gmii_rx_dv falls; the result is registered below.
    always_comb begin
        done_now   = 1'b0;
        status_now = '0;
        if (!gmii_rx_dv) begin
            if (state == S_DATA) begin
                done_now                = 1'b1;
                status_now[ST_CRC_ERR]  = (crc != CRC32_RESIDUE);
                status_now[ST_RUNT]     = (byte_cnt < MIN_FRAME_C);
                status_now[ST_OVERSIZE] = oversize;
                status_now[ST_PHY_ERR]  = phy_err;
            end else if ((state == S_DROP) && pre_err) begin
                done_now                    = 1'b1;
                status_now[ST_PREAMBLE_ERR] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done   <= 1'b0;
            frame_status <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
        end else begin
            frame_done <= done_now;
            if (done_now) begin
                frame_status <= status_now;
                if (status_now == '0) begin
                    if (good_cnt != '1) begin
                        good_cnt <= good_cnt + 1'b1;
                    end
                end else if (bad_cnt != '1) begin
                    bad_cnt <= bad_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Randomized self-checking bench for eth_rx_framer against a frame-level reference model.
module tb_eth_rx_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  rx_data;
    logic        rx_dv;
    logic        rx_er;
    logic        frame_done;
    logic [4:0]  frame_status;
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;

    always #4 clk = ~clk;

    eth_rx_framer #(
        .MIN_PREAMBLE (1),
        .MIN_FRAME    (64),
        .MAX_FRAME    (1518),
        .CNT_W        (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gmii_rxd     (gmii_rxd),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rx_er   (gmii_rx_er),
        .rx_data      (rx_data),
        .rx_dv        (rx_dv),
        .rx_er        (rx_er),
        .frame_done   (frame_done),
        .frame_status (frame_status),
        .good_cnt     (good_cnt),
        .bad_cnt      (bad_cnt)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int b0_cyc, idle_cyc;
    int first_dv, last_dv, done_cyc;
    int exp_good = 0, exp_bad = 0;

    logic [7:0] frm[$];
    logic [7:0] got_data[$];
    logic       got_er[$];
    logic [4:0] got_st[$];
    logic [7:0] exp_data[$];
    logic       exp_er[$];
    logic [4:0] exp_st[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_dv === 1'b1) begin
            got_data.push_back(rx_data);
            got_er.push_back(rx_er);
            if (first_dv < 0) first_dv = cyc;
            last_dv = cyc;
        end
        if (frame_done === 1'b1) begin
            got_st.push_back(frame_status);
            done_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] crc32_calc(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'b0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [4:0] model_status(input int n, input int er_idx);
        logic [4:0]  s = '0;
        logic [31:0] fcs;
        fcs  = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
        s[0] = (crc32_calc(n - 4) != fcs);
        s[1] = (n < 64);
        s[2] = (n > 1518);
        s[3] = (er_idx >= 0) && (er_idx < n);
        return s;
    endfunction

    task automatic build_frame(input int n);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < n - 4; i++) frm.push_back(8'($urandom));
        fcs = crc32_calc(n - 4);
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
    endtask

    task automatic expect_frame(input int er_idx, input bit pre_ok);
        logic [4:0] s;
        int n, nfwd;
        n = frm.size();
        if (!pre_ok) begin
            s = 5'b10000;
        end else begin
            s    = model_status(n, er_idx);
            nfwd = (n - 4 < 1518) ? n - 4 : 1518;
            for (int i = 0; i < nfwd; i++) begin
                exp_data.push_back(frm[i]);
                exp_er.push_back(i == er_idx);
            end
        end
        exp_st.push_back(s);
        if (s == 5'b0) exp_good++;
        else exp_bad++;
    endtask

    function automatic int stream_mism();
        int m = 0, n;
        n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) if (got_data[i] !== exp_data[i] || got_er[i] !== exp_er[i]) m++;
        return m + ((got_data.size() > exp_data.size()) ? got_data.size() - exp_data.size()
                                                          : exp_data.size() - got_data.size());
    endfunction

    function automatic int status_mism();
        int m = 0, n;
        n = (got_st.size() < exp_st.size()) ? got_st.size() : exp_st.size();
        for (int i = 0; i < n; i++) if (got_st[i] !== exp_st[i]) m++;
        return m + ((got_st.size() > exp_st.size()) ? got_st.size() - exp_st.size()
                                                      : exp_st.size() - got_st.size());
    endfunction

    // ---------------- stimulus ----------------
    task automatic clear_mon();
        got_data.delete(); got_er.delete(); got_st.delete();
        exp_data.delete(); exp_er.delete(); exp_st.delete();
        first_dv = -1; last_dv = -1; done_cyc = -1;
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        @(posedge clk); #1;
        gmii_rxd = d; gmii_rx_dv = dv; gmii_rx_er = er;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send(input int npre, input logic [7:0] sfd, input int er_idx);
        for (int i = 0; i < npre; i++) drive(8'h55, 1'b1, 1'b0);
        drive(sfd, 1'b1, 1'b0);
        foreach (frm[i]) begin
            drive(frm[i], 1'b1, i == er_idx);
            if (i == 0) b0_cyc = cyc;
        end
        drive(8'h00, 1'b0, 1'b0);
        idle_cyc = cyc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0; gmii_rxd = '0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors += 7;
        if (rx_data !== 8'h00) begin $display("FAIL reset_rx_data: got %h want 00", rx_data); miscompares++; end
        if (rx_dv !== 1'b0) begin $display("FAIL reset_rx_dv: got %b want 0", rx_dv); miscompares++; end
        if (rx_er !== 1'b0) begin $display("FAIL reset_rx_er: got %b want 0", rx_er); miscompares++; end
        if (frame_done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", frame_done); miscompares++; end
        if (frame_status !== 5'b0) begin $display("FAIL reset_status: got %b want 00000", frame_status); miscompares++; end
        if (good_cnt !== 32'd0) begin $display("FAIL reset_good: got %0d want 0", good_cnt); miscompares++; end
        if (bad_cnt !== 32'd0) begin $display("FAIL reset_bad: got %0d want 0", bad_cnt); miscompares++; end
        @(posedge clk); #1; rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_good;
        clear_mon(); build_frame(64); expect_frame(-1, 1'b1);
        send(7, 8'hD5, -1); idle(4);
        vectors += 7;
        if (got_data.size() != 60) begin $display("FAIL good_len: got %0d want 60", got_data.size()); miscompares++; end
        if (stream_mism() != 0) begin $display("FAIL good_data: %0d bad bytes want 0", stream_mism()); miscompares++; end
        if (first_dv - b0_cyc != 5) begin $display("FAIL good_latency: got %0d want 5", first_dv - b0_cyc); miscompares++; end
        if (last_dv != idle_cyc) begin $display("FAIL good_dv_end: got cyc %0d want %0d", last_dv, idle_cyc); miscompares++; end
        if (status_mism() != 0) begin $display("FAIL good_status: %0d status errors, first got %b want 00000", status_mism(), got_st.size() ? got_st[0] : 5'bx); miscompares++; end
        if (done_cyc != idle_cyc + 1) begin $display("FAIL good_done_time: got cyc %0d want %0d", done_cyc, idle_cyc + 1); miscompares++; end
        if (good_cnt !== 32'(exp_good) || bad_cnt !== 32'(exp_bad)) begin $display("FAIL good_counters: got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); miscompares++; end
    endtask

    task automatic test_crc_err;
        clear_mon(); build_frame(64);
        frm[20] = frm[20] ^ 8'h01;
        expect_frame(-1, 1'b1);
        send(7, 8'hD5, -1); idle(4);
        vectors += 4;
        if (got_data.size() != 60) begin $display("FAIL crc_len: got %0d want 60", got_data.size()); miscompares++; end
        if (stream_mism() != 0) begin $display("FAIL crc_data: %0d bad bytes want 0", stream_mism()); miscompares++; end
        if (status_mism() != 0) begin $display("FAIL crc_status: got %b want %b", got_st.size() ? got_st[0] : 5'bx, exp_st[0]); miscompares++; end
        if (bad_cnt !== 32'(exp_bad) || good_cnt !== 32'(exp_good)) begin $display("FAIL crc_counters: got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); miscompares++; end
    endtask

    task automatic test_runt;
        clear_mon(); build_frame(40); expect_frame(-1, 1'b1);
        send(3, 8'hD5, -1); idle(4);
        vectors += 3;
        if (got_data.size() != 36) begin $display("FAIL runt_len: got %0d want 36", got_data.size()); miscompares++; end
        if (status_mism() != 0) begin $display("FAIL runt_status: got %b want %b", got_st.size() ? got_st[0] : 5'bx, exp_st[0]); miscompares++; end
        if (bad_cnt !== 32'(exp_bad)) begin $display("FAIL runt_bad_cnt: got %0d want %0d", bad_cnt, exp_bad); miscompares++; end
    endtask

    task automatic test_phy_err;
        clear_mon(); build_frame(64); expect_frame(30, 1'b1);
        send(7, 8'hD5, 30); idle(4);
        vectors += 3;
        if ((got_er.size() > 30 ? got_er[30] : 1'bx) !== 1'b1) begin $display("FAIL phy_er_align: got %b want 1", got_er.size() > 30 ? got_er[30] : 1'bx); miscompares++; end
        if (stream_mism() != 0) begin $display("FAIL phy_stream: %0d bad bytes want 0", stream_mism()); miscompares++; end
        if (status_mism() != 0) begin $display("FAIL phy_status: got %b want %b", got_st.size() ? got_st[0] : 5'bx, exp_st[0]); miscompares++; end
    endtask

    task automatic test_preamble;
        clear_mon(); build_frame(64); expect_frame(-1, 1'b0);
        send(2, 8'hAA, -1); idle(4);
        vectors += 3;
        if (got_data.size() != 0) begin $display("FAIL pre_dv: got %0d bytes want 0", got_data.size()); miscompares++; end
        if (status_mism() != 0) begin $display("FAIL pre_status: got %b want 10000", got_st.size() ? got_st[0] : 5'bx); miscompares++; end
        if (bad_cnt !== 32'(exp_bad)) begin $display("FAIL pre_bad_cnt: got %0d want %0d", bad_cnt, exp_bad); miscompares++; end
        clear_mon(); build_frame(64);
        send(0, 8'h12, -1); idle(4);
        vectors += 3;
        if (got_data.size() != 0) begin $display("FAIL junk_dv: got %0d bytes want 0", got_data.size()); miscompares++; end
        if (got_st.size() != 0) begin $display("FAIL junk_done: got %0d pulses want 0", got_st.size()); miscompares++; end
        if (good_cnt !== 32'(exp_good) || bad_cnt !== 32'(exp_bad)) begin $display("FAIL junk_counters: got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); miscompares++; end
    endtask

    task automatic test_oversize;
        clear_mon(); build_frame(1600); expect_frame(-1, 1'b1);
        send(7, 8'hD5, -1); idle(4);
        vectors += 4;
        if (got_data.size() != 1518) begin $display("FAIL over_len: got %0d want 1518", got_data.size()); miscompares++; end
        if (last_dv - first_dv + 1 != 1518) begin $display("FAIL over_contig: got span %0d want 1518", last_dv - first_dv + 1); miscompares++; end
        if (stream_mism() != 0) begin $display("FAIL over_data: %0d bad bytes want 0", stream_mism()); miscompares++; end
        if (status_mism() != 0) begin $display("FAIL over_status: got %b want %b", got_st.size() ? got_st[0] : 5'bx, exp_st[0]); miscompares++; end
    endtask

    task automatic test_back_to_back;
        int n, er_idx;
        clear_mon();
        for (int f = 0; f < 12; f++) begin
            n = $urandom_range(40, 200);
            build_frame(n);
            er_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            if ($urandom_range(0, 3) == 0) begin
                int k = $urandom_range(0, n - 1);
                frm[k] = frm[k] ^ 8'(1 << $urandom_range(0, 7));
            end
            expect_frame(er_idx, 1'b1);
            send($urandom_range(1, 10), 8'hD5, er_idx);
        end
        idle(5);
        vectors += 4;
        if (got_data.size() != exp_data.size()) begin $display("FAIL b2b_len: got %0d want %0d", got_data.size(), exp_data.size()); miscompares++; end
        if (stream_mism() != 0) begin $display("FAIL b2b_stream: %0d bad bytes want 0", stream_mism()); miscompares++; end
        if (status_mism() != 0) begin $display("FAIL b2b_status: %0d status errors want 0 (got %0d frames want %0d)", status_mism(), got_st.size(), exp_st.size()); miscompares++; end
        if (good_cnt !== 32'(exp_good) || bad_cnt !== 32'(exp_bad)) begin $display("FAIL b2b_counters: got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); miscompares++; end
    endtask

    task automatic test_reset_mid;
        clear_mon(); build_frame(64);
        if (frm[31] == 8'h55) frm[31] = 8'h56;
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            gmii_rxd = frm[i]; gmii_rx_dv = 1'b1; gmii_rx_er = 1'b0;
            rst_n = (i != 30);
            if (i == 31) begin
                @(negedge clk);
                vectors += 5;
                if (rx_dv !== 1'b0 || rx_data !== 8'h00 || rx_er !== 1'b0) begin $display("FAIL rstmid_data: got dv=%b data=%h er=%b want 0/00/0", rx_dv, rx_data, rx_er); miscompares++; end
                if (frame_done !== 1'b0) begin $display("FAIL rstmid_done: got %b want 0", frame_done); miscompares++; end
                if (frame_status !== 5'b0) begin $display("FAIL rstmid_status: got %b want 00000", frame_status); miscompares++; end
                if (good_cnt !== 32'd0) begin $display("FAIL rstmid_good: got %0d want 0", good_cnt); miscompares++; end
                if (bad_cnt !== 32'd0) begin $display("FAIL rstmid_bad: got %0d want 0", bad_cnt); miscompares++; end
                clear_mon();
            end
        end
        idle(5);
        exp_good = 0; exp_bad = 0;
        vectors += 2;
        if (got_data.size() != 0) begin $display("FAIL rstmid_silent_dv: got %0d bytes want 0", got_data.size()); miscompares++; end
        if (got_st.size() != 0) begin $display("FAIL rstmid_silent_done: got %0d pulses want 0", got_st.size()); miscompares++; end
        clear_mon(); build_frame(64); expect_frame(-1, 1'b1);
        send(7, 8'hD5, -1); idle(4);
        vectors += 2;
        if (status_mism() != 0) begin $display("FAIL rstmid_next_status: got %b want 00000", got_st.size() ? got_st[0] : 5'bx); miscompares++; end
        if (good_cnt !== 32'd1 || bad_cnt !== 32'd0) begin $display("FAIL rstmid_next_counters: got %0d/%0d want 1/0", good_cnt, bad_cnt); miscompares++; end
    endtask

    initial begin
        first_dv = -1; last_dv = -1; done_cyc = -1;
        test_reset();
        test_good();
        test_crc_err();
        test_runt();
        test_phy_err();
        test_preamble();
        test_oversize();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
